// File: rtl/dmp_serial_stream_pkg.sv
// ---------------------------------------------------------------------------
// dmp_pkg : shared types and helpers for the dmp_serial_stream block.
//   state_t          : serializer round state (WAIT_SYNC -> SEND -> RELEASE).
//   beats_per_thread : number of LANES-wide beats needed for one thread vector.
//   idx_width        : index width for a count, never narrower than one bit.
//   DEF_*            : default geometry, used as interface parameter defaults.
// Optional feature macro used by the block: DMP_THREAD_MASK_EN.
// ---------------------------------------------------------------------------
package dmp_pkg;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SEND      = 2'd1,
    RELEASE   = 2'd2
  } state_t;

  function automatic int beats_per_thread(input int nodes, input int lanes);
    return nodes / lanes;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_HW_THREADS   = 8;
  localparam int DEF_NODES_PER_THREAD = 32;
  localparam int DEF_DATA_W           = 64;
  localparam int DEF_LANES            = 8;
  localparam int DEF_TID_W            = idx_width(DEF_NUM_HW_THREADS);
  localparam int DEF_BEAT_W           = idx_width(beats_per_thread(DEF_NODES_PER_THREAD, DEF_LANES));

endpackage

// File: rtl/dmp_serial_stream_if.sv
// ---------------------------------------------------------------------------
// dmp_serial_stream_if : valid/ready beat stream from the serializer to the
// ordered apply stage.
//   valid     : beat available (master -> slave)
//   ready     : slave accepts the beat when valid && ready (slave -> master)
//   data      : LANES entries of DATA_W bits, lane 0 = lowest node of the beat
//   thread_id : thread owning the beat
//   beat_idx  : beat index within that thread
//   start     : first beat of the round
//   last      : final beat of the round
// Modports: master (serializer side), slave (consumer side).
// Optional feature macro of the block: DMP_THREAD_MASK_EN (no effect here).
// ---------------------------------------------------------------------------
interface dmp_serial_stream_if
  import dmp_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TID_W  = DEF_TID_W,
  parameter int BEAT_W = DEF_BEAT_W
);
  logic                         valid;
  logic                         ready;
  logic [LANES-1:0][DATA_W-1:0] data;
  logic [TID_W-1:0]             thread_id;
  logic [BEAT_W-1:0]            beat_idx;
  logic                         start;
  logic                         last;

  modport master (output valid, data, thread_id, beat_idx, start, last, input ready);
  modport slave  (input valid, data, thread_id, beat_idx, start, last, output ready);
endinterface

// File: rtl/dmp_serial_stream_beat_counter.sv
// ---------------------------------------------------------------------------
// dmp_beat_counter : two-level (beat, thread) wrap counter.
//   clk_i    : clock
//   srst_i   : synchronous active-high reset
//   clr_i    : synchronous clear to the first beat of the first thread
//   en_i     : advance one beat (beat wraps into the next thread)
//   mask_i   : participating threads (only with DMP_THREAD_MASK_EN)
//   thread_o : current thread, beat_o : current beat
//   first_o  : current position is the first beat of the round
//   last_o   : current position is the final beat of the round
//   any_o    : at least one thread participates
// With DMP_THREAD_MASK_EN defined, masked-out threads are skipped through a
// combinational next-thread search, so no bubble beats appear between threads.
// ---------------------------------------------------------------------------
module dmp_beat_counter
  import dmp_pkg::*;
#(
  parameter int NUM_THREADS = 8,
  parameter int BEATS       = 4,
  parameter int TID_W       = idx_width(NUM_THREADS),
  parameter int BEAT_W      = idx_width(BEATS)
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic                   clr_i,
  input  logic                   en_i,
`ifdef DMP_THREAD_MASK_EN
  input  logic [NUM_THREADS-1:0] mask_i,
`endif
  output logic [TID_W-1:0]       thread_o,
  output logic [BEAT_W-1:0]      beat_o,
  output logic                   first_o,
  output logic                   last_o,
  output logic                   any_o
);

  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BEATS - 1);
  localparam logic [TID_W-1:0]  TID_MAX  = TID_W'(NUM_THREADS - 1);

  logic [TID_W-1:0]  thread_q, thread_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [TID_W-1:0]  first_idx, last_idx, next_idx;
  logic              beat_wrap;

  assign beat_wrap = (beat_q == BEAT_MAX);

`ifdef DMP_THREAD_MASK_EN
  // Lowest set bit, highest set bit, and lowest set bit above the current
  // thread. An empty mask leaves all three at zero; the caller never enters
  // SEND in that case.
  always_comb begin
    first_idx = '0;
    last_idx  = '0;
    next_idx  = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (mask_i[i]) first_idx = TID_W'(i);
    end
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (mask_i[i]) last_idx = TID_W'(i);
    end
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (mask_i[i] && (i > int'(thread_q))) next_idx = TID_W'(i);
    end
  end
  assign any_o = |mask_i;
`else
  assign first_idx = '0;
  assign last_idx  = TID_MAX;
  assign next_idx  = (thread_q == TID_MAX) ? '0 : thread_q + 1'b1;
  assign any_o     = 1'b1;
`endif

  always_comb begin
    thread_d = thread_q;
    beat_d   = beat_q;
    if (clr_i) begin
      thread_d = first_idx;
      beat_d   = '0;
    end else if (en_i) begin
      if (beat_wrap) begin
        beat_d   = '0;
        thread_d = next_idx;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      thread_q <= '0;
      beat_q   <= '0;
    end else begin
      thread_q <= thread_d;
      beat_q   <= beat_d;
    end
  end

  assign thread_o = thread_q;
  assign beat_o   = beat_q;
  assign first_o  = (thread_q == first_idx) && (beat_q == '0);
  assign last_o   = (thread_q == last_idx) && beat_wrap;

endmodule

// File: rtl/dmp_serial_stream.sv
// ---------------------------------------------------------------------------
// dmp_serial_stream : barrier-synchronised, deterministic-order serializer.
// Waits until every participating thread has raised done (sticky), then
// streams each thread's pagerank vector in ascending thread order, LANES
// entries per beat, pulses release for one cycle and counts the round.
//   clock_i            : clock, rising edge
//   reset_i            : synchronous active-high reset, aborts any round
//   page_rank_gather_i : per-thread vectors, held stable from done to release
//   done_i             : per-thread gather complete (pulse or level)
//   thread_mask_i      : participating threads (only with DMP_THREAD_MASK_EN)
//   strm               : beat stream (dmp_serial_stream_if.master)
//   release_o          : one-cycle pulse, round complete
//   epoch_o            : completed rounds, wraps at 2^EPOCH_W
// Optional feature macro: DMP_THREAD_MASK_EN.
// ---------------------------------------------------------------------------
module dmp_serial_stream
  import dmp_pkg::*;
#(
  parameter int NUM_HW_THREADS   = 8,
  parameter int NODES_PER_THREAD = 32,
  parameter int DATA_W           = 64,
  parameter int LANES            = 8,
  parameter int EPOCH_W          = 16
) (
  input  logic                                                  clock_i,
  input  logic                                                  reset_i,
  input  logic [NUM_HW_THREADS-1:0][NODES_PER_THREAD-1:0][DATA_W-1:0] page_rank_gather_i,
  input  logic [NUM_HW_THREADS-1:0]                             done_i,
`ifdef DMP_THREAD_MASK_EN
  input  logic [NUM_HW_THREADS-1:0]                             thread_mask_i,
`endif
  dmp_serial_stream_if.master                                   strm,
  output logic                                                  release_o,
  output logic [EPOCH_W-1:0]                                    epoch_o
);

  localparam int BEATS  = beats_per_thread(NODES_PER_THREAD, LANES);
  localparam int TID_W  = idx_width(NUM_HW_THREADS);
  localparam int BEAT_W = idx_width(BEATS);
  localparam int NSLOT  = NUM_HW_THREADS * BEATS;

  if (NUM_HW_THREADS < 1) begin : g_bad_threads
    $error("dmp_serial_stream: NUM_HW_THREADS must be >= 1");
  end
  if ((NODES_PER_THREAD % LANES) != 0) begin : g_bad_lanes
    $error("dmp_serial_stream: NODES_PER_THREAD must be a multiple of LANES");
  end

  state_t                    state_q;
  logic                      valid_q;
  logic                      release_q;
  logic [EPOCH_W-1:0]        epoch_q;
  logic [NUM_HW_THREADS-1:0] done_seen_q, done_seen_d;
  logic [NUM_HW_THREADS-1:0] eff_mask;
  logic                      barrier;
  logic                      accept;
  logic [TID_W-1:0]          thread_cnt;
  logic [BEAT_W-1:0]         beat_cnt;
  logic                      cnt_first, cnt_last, cnt_any;

  // Bits raised this cycle count toward the barrier immediately.
  assign done_seen_d = done_seen_q | done_i;
  assign barrier     = &(done_seen_d | ~eff_mask);
  assign accept      = valid_q & strm.ready;

`ifdef DMP_THREAD_MASK_EN
  logic [NUM_HW_THREADS-1:0] mask_q;

  // The live mask is used while waiting; it is frozen for the round once the
  // barrier is passed so the skip pattern cannot change mid-stream.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      mask_q <= '0;
    end else if (state_q == WAIT_SYNC) begin
      mask_q <= thread_mask_i;
    end
  end
  assign eff_mask = (state_q == WAIT_SYNC) ? thread_mask_i : mask_q;
`else
  assign eff_mask = '1;
`endif

  // The counter is held at the round's first position for the whole of
  // WAIT_SYNC, so SEND always starts from the first participating thread.
  dmp_beat_counter #(
    .NUM_THREADS (NUM_HW_THREADS),
    .BEATS       (BEATS),
    .TID_W       (TID_W),
    .BEAT_W      (BEAT_W)
  ) u_cnt (
    .clk_i    (clock_i),
    .srst_i   (reset_i),
    .clr_i    (state_q == WAIT_SYNC),
    .en_i     (accept),
`ifdef DMP_THREAD_MASK_EN
    .mask_i   (eff_mask),
`endif
    .thread_o (thread_cnt),
    .beat_o   (beat_cnt),
    .first_o  (cnt_first),
    .last_o   (cnt_last),
    .any_o    (cnt_any)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= WAIT_SYNC;
      valid_q     <= 1'b0;
      release_q   <= 1'b0;
      epoch_q     <= '0;
      done_seen_q <= '0;
    end else begin
      release_q <= 1'b0;
      case (state_q)
        WAIT_SYNC: begin
          done_seen_q <= done_seen_d;
          if (barrier) begin
            if (cnt_any) begin
              state_q <= SEND;
              valid_q <= 1'b1;
            end else begin
              // Nothing participates: close the round without any beat.
              state_q   <= RELEASE;
              release_q <= 1'b1;
            end
          end
        end
        SEND: begin
          // Early dones for the next round are collected but not acted on.
          done_seen_q <= done_seen_d;
          if (accept && cnt_last) begin
            state_q   <= RELEASE;
            valid_q   <= 1'b0;
            release_q <= 1'b1;
          end
        end
        RELEASE: begin
          // Clear the barrier; a done arriving in this very cycle survives.
          done_seen_q <= done_i;
          epoch_q     <= epoch_q + 1'b1;
          state_q     <= WAIT_SYNC;
        end
        default: begin
          state_q <= WAIT_SYNC;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Beat data mux: one slot per (thread, beat) pair, zero unless selected,
  // so the stream carries zeros whenever no beat is presented.
  logic [LANES-1:0][DATA_W-1:0] slot_data [NSLOT];
  logic [LANES-1:0][DATA_W-1:0] data_mux;

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
    assign slot_data[gi] =
      (valid_q && (thread_cnt == TID_W'(gi / BEATS)) && (beat_cnt == BEAT_W'(gi % BEATS)))
        ? page_rank_gather_i[gi / BEATS][(gi % BEATS) * LANES +: LANES]
        : '0;
  end

  always_comb begin
    data_mux = '0;
    for (int i = 0; i < NSLOT; i++) begin
      data_mux = data_mux | slot_data[i];
    end
  end

  assign strm.valid     = valid_q;
  assign strm.data      = data_mux;
  assign strm.thread_id = valid_q ? thread_cnt : '0;
  assign strm.beat_idx  = valid_q ? beat_cnt : '0;
  assign strm.start     = valid_q & cnt_first;
  assign strm.last      = valid_q & cnt_last;
  assign release_o      = release_q;
  assign epoch_o        = epoch_q;

endmodule

// File: doc/dmp_serial_stream.md
Name: dmp_serial_stream

Overview:
- Parametrised deterministic-order serializer between the gather phase and the ordered apply stage.
- Barrier-syncs all hardware threads on sticky done flags, then streams each thread's pagerank vector in ascending thread order, LANES nodes per beat, over a valid/ready handshake.
- Repeats per round (epoch): pulses a release to the threads after the last accepted beat, then re-arms.

Parameters:
- NUM_HW_THREADS, 8, number of graph partitions/threads; must be >=1.
- NODES_PER_THREAD, 32, pagerank entries per thread vector.
- DATA_W, 64, bits per pagerank entry.
- LANES, 8, entries per output beat; NODES_PER_THREAD must be a multiple of LANES (elaboration-time assertion).
- EPOCH_W, 16, width of the round counter.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- page_rank_gather  in  [NUM_HW_THREADS][NODES_PER_THREAD][DATA_W]  per-thread vectors; sources hold them stable from done until release.
- done  in  [NUM_HW_THREADS]  per-thread gather-complete; pulse or level.
- stream_valid  out  1  beat available.
- stream_ready  in  1  downstream accepts the beat when valid&&ready.
- stream_data  out  [LANES][DATA_W]  entries beat_idx*LANES .. beat_idx*LANES+LANES-1 of the current thread.
- stream_thread_id  out  clog2(NUM_HW_THREADS) (min 1)  thread of current beat.
- stream_beat_idx  out  clog2(NODES_PER_THREAD/LANES) (min 1)  beat within thread.
- stream_start  out  1  first beat of round (thread 0, beat 0).
- stream_last  out  1  final beat of round.
- release  out  1  one-cycle pulse: round complete, threads may start the next gather.
- epoch  out  EPOCH_W  count of completed rounds.

Behaviour:
- Reset values: stream_valid=0, stream_start=0, stream_last=0, release=0, stream_data=0, stream_thread_id=0, stream_beat_idx=0, epoch=0, done_seen=0, state=WAIT_SYNC. Reset in any state aborts the round immediately; the next cycle behaves as post-reset.
- done_seen[i] is set on any cycle done[i]=1 and is sticky.
- WAIT_SYNC:
  - stream_valid=0.
  - When done_seen is all-ones (including bits set this cycle), go to SEND next cycle with thread=0, beat=0.
  - Barrier-to-first-valid latency is 1 cycle.
- SEND:
  - stream_valid=1.
  - stream_data is combinational from page_rank_gather[thread][beat*LANES +: LANES].
  - stream_start = (thread==0 && beat==0).
  - stream_last = (thread==NUM_HW_THREADS-1 && beat==BEATS-1).
  - On valid&&ready: advance beat, wrapping to 0 and incrementing thread.
  - On an accepted last beat: go to RELEASE.
  - Without ready: all outputs hold unchanged; no beat is skipped or repeated.
  - One beat per cycle maximum.
- RELEASE (1 cycle):
  - release=1, stream_valid=0.
  - done_seen is cleared, except bits whose done input is high this same cycle; set wins.
  - epoch increments modulo 2^EPOCH_W.
  - Next state: WAIT_SYNC.
- A done[i] pulse arriving during SEND is held in done_seen and does not disturb the current round. Because RELEASE clears it, threads must signal done after release; a level held through release re-arms the barrier.
- Degenerate case BEATS=1 (LANES==NODES_PER_THREAD): one beat per thread. With NUM_HW_THREADS=1 the single beat has both start and last set.
- Ordering is deterministic: thread ascending, beat ascending, independent of done arrival order.

Optional Feature:
- Macro DMP_THREAD_MASK_EN.
- When defined:
  - Adds input thread_mask [NUM_HW_THREADS], sampled in WAIT_SYNC.
  - The barrier requires done_seen|~thread_mask to be all-ones.
  - SEND skips masked threads with zero bubble cycles; the next-thread search is combinational.
  - stream_start and stream_last refer to the first and last unmasked threads.
  - An all-zero mask goes straight to RELEASE with no beats and still increments epoch.
- When undefined: no port; all threads participate.

Decomposition:
- Package dmp_pkg:
  - typedef state_t {WAIT_SYNC, SEND, RELEASE}.
  - function beats_per_thread(NODES, LANES).
  - localparams for thread-ID and beat-index widths.
- Sub-module dmp_beat_counter: two-level wrap counter (beat, thread) with enable, sync clear, and last-beat flag. The mask-skip variant is selected by the same macro.

Test Plan (NUM_HW_THREADS=4, NODES_PER_THREAD=8, LANES=4, DATA_W=64, entry value = {thread,node}):
- Reset, then done pulses in order 3,1,0,2 on cycles 2,5,7,9 -> first valid at cycle 10. Eight beats follow, ordered (0,0),(0,1),(1,0)..(3,1). Beat (2,1) data = entries 0x24..0x27. start on beat 1 only, last on beat 8 only.
- ready=1 throughout -> 8 consecutive valid cycles, release 1 cycle after the last beat, epoch=1.
- ready toggled 0,0,1 repeatedly -> each beat held stable across stall cycles; still exactly 8 accepted beats, none duplicated.
- Thread 2 pulses done again mid-SEND of round 0 -> round 0 unaffected; after release the bit is clear and round 1 waits for all four threads.
- reset asserted during the 4th beat -> next cycle valid=0, epoch=0, done_seen=0; a full round then completes normally.
- DMP_THREAD_MASK_EN with mask=4'b1010 -> beats only for threads 1 and 3. start on (1,0), last on (3,1), 4 beats, no bubbles. mask=0 -> release with zero beats.
